// File: rtl/rr_multi_issue_select.sv
// Multi-issue select stage: the reservation-station payload RAM, a round-robin pick of up to
// ISSUE_WIDTH ready entries per cycle, and a registered valid/ready issue stage to register read.
module rr_multi_issue_select #(
    parameter int RS_ENTRIES  = 16,
    parameter int ISSUE_WIDTH = 2,
    parameter int DISP_WIDTH  = 2,
    parameter int PAYLOAD_W   = 64,
    parameter int IDX_W       = $clog2(RS_ENTRIES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DISP_WIDTH-1:0]             disp_valid,
    input  logic [DISP_WIDTH*IDX_W-1:0]       disp_index,
    input  logic [DISP_WIDTH*PAYLOAD_W-1:0]   disp_payload,
    input  logic [RS_ENTRIES-1:0]             req_vec,
    output logic [ISSUE_WIDTH-1:0]            clear_en,
    output logic [ISSUE_WIDTH*IDX_W-1:0]      clear_index,
    output logic [ISSUE_WIDTH-1:0]            iss_valid,
    output logic [ISSUE_WIDTH*IDX_W-1:0]      iss_index,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]  iss_payload,
    input  logic                              iss_ready
);

    localparam logic [IDX_W:0] RS_N = (IDX_W+1)'(RS_ENTRIES);

    logic [PAYLOAD_W-1:0]             ram_q [RS_ENTRIES];
    logic [IDX_W-1:0]                 ptr_q, ptr_d;
    logic [ISSUE_WIDTH-1:0]           iss_valid_q;
    logic [ISSUE_WIDTH*IDX_W-1:0]     iss_index_q;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] iss_payload_q;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] rd_payload;
    logic                             stall;

    // Modular add for entry indices; operands are always below RS_ENTRIES, so one subtract suffices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W:0]   off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + off;
        if (s >= RS_N) s = s - RS_N;
        return s[IDX_W-1:0];
    endfunction

    assign stall = (|iss_valid_q) & ~iss_ready;

    // Circular scan from ptr_q; the n-th set bit found fills slot n, so slots are gap-free.
    always_comb begin
        int             n_grant;
        logic [IDX_W-1:0] idx;
        // NOTE: every combinational output gets a default first, otherwise paths that skip an
        // assignment would infer latches.
        clear_en    = '0;
        clear_index = '0;
        ptr_d       = ptr_q;
        n_grant     = 0;
        idx         = '0;
        if (rst && !stall) begin
            for (int off = 0; off < RS_ENTRIES; off++) begin
                // NOTE: blocking assignments here make idx/n_grant visible to later iterations
                // in the same evaluation; registered state below uses non-blocking only.
                idx = wrap_add(ptr_q, (IDX_W+1)'(off));
                if (req_vec[idx] && n_grant < ISSUE_WIDTH) begin
                    for (int k = 0; k < ISSUE_WIDTH; k++) begin
                        if (n_grant == k) begin
                            clear_en[k]                    = 1'b1;
                            clear_index[k*IDX_W +: IDX_W]  = idx;
                        end
                    end
                    ptr_d   = wrap_add(idx, (IDX_W+1)'(1));
                    n_grant = n_grant + 1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            rd_payload[k*PAYLOAD_W +: PAYLOAD_W] = ram_q[clear_index[k*IDX_W +: IDX_W]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_valid_q   <= '0;
            iss_index_q   <= '0;
            iss_payload_q <= '0;
            ptr_q         <= '0;
        end else if (!stall) begin
            iss_valid_q <= clear_en;
            ptr_q       <= ptr_d;
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (clear_en[k]) begin
                    iss_index_q[k*IDX_W +: IDX_W]           <= clear_index[k*IDX_W +: IDX_W];
                    iss_payload_q[k*PAYLOAD_W +: PAYLOAD_W] <= rd_payload[k*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    // Later ports overwrite earlier ones on an index collision because the last NBA wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the payload RAM is deliberately reset, so a freshly reset entry issues zero;
            // this forces it into flops rather than a RAM macro.
            for (int r = 0; r < RS_ENTRIES; r++) ram_q[r] <= '0;
        end else begin
            for (int p = 0; p < DISP_WIDTH; p++) begin
                if (disp_valid[p]) begin
                    ram_q[disp_index[p*IDX_W +: IDX_W]] <= disp_payload[p*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_index   = iss_index_q;
    assign iss_payload = iss_payload_q;

endmodule

// File: tb/tb_rr_multi_issue_select.sv
// Randomised and directed bench for rr_multi_issue_select against a queue-based select model.
module tb_rr_multi_issue_select;

    localparam int RS = 16;
    localparam int IW = 2;
    localparam int DW = 2;
    localparam int PW = 64;
    localparam int XW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DW-1:0]     disp_valid = '0;
    logic [DW*XW-1:0]  disp_index = '0;
    logic [DW*PW-1:0]  disp_payload = '0;
    logic [RS-1:0]     req_vec = '0;
    logic [IW-1:0]     clear_en;
    logic [IW*XW-1:0]  clear_index;
    logic [IW-1:0]     iss_valid;
    logic [IW*XW-1:0]  iss_index;
    logic [IW*PW-1:0]  iss_payload;
    logic              iss_ready = 1'b1;

    rr_multi_issue_select #(
        .RS_ENTRIES(RS), .ISSUE_WIDTH(IW), .DISP_WIDTH(DW), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_index(disp_index), .disp_payload(disp_payload),
        .req_vec(req_vec),
        .clear_en(clear_en), .clear_index(clear_index),
        .iss_valid(iss_valid), .iss_index(iss_index), .iss_payload(iss_payload),
        .iss_ready(iss_ready)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: plain arrays and integers.
    logic [PW-1:0] m_ram [RS];
    int            m_ptr;
    logic [IW-1:0] m_valid;
    int            m_idx [IW];
    logic [PW-1:0] m_pay [IW];

    logic [IW-1:0]    last_en;
    logic [IW*XW-1:0] last_ci;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < RS; r++) m_ram[r] = '0;
        m_ptr   = 0;
        m_valid = '0;
        for (int k = 0; k < IW; k++) begin
            m_idx[k] = 0;
            m_pay[k] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_index", iss_index, 0);
        check("rst_iss_payload", iss_payload, 0);
        check("rst_clear_en", clear_en, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive at negedge, check combinational grants, then registered issue after the edge.
    task automatic step(input logic [DW-1:0] dv, input logic [DW*XW-1:0] di,
                        input logic [DW*PW-1:0] dp, input logic [RS-1:0] rq, input logic rdy);
        int            g[$];
        logic [IW-1:0] exp_en;
        logic          stalled;
        logic [PW-1:0] pre [IW];
        int            overlap;
        disp_valid   = dv;
        disp_index   = di;
        disp_payload = dp;
        req_vec      = rq;
        iss_ready    = rdy;
        #1;
        stalled = (m_valid != 0) && !rdy;
        exp_en  = '0;
        if (!stalled) begin
            for (int off = 0; off < RS; off++) begin
                if (rq[(m_ptr + off) % RS] && g.size() < IW) g.push_back((m_ptr + off) % RS);
            end
        end
        for (int k = 0; k < g.size(); k++) exp_en[k] = 1'b1;
        last_en = clear_en;
        last_ci = clear_index;
        check("clear_en", clear_en, exp_en);
        for (int k = 0; k < g.size(); k++) begin
            check($sformatf("clear_index[%0d]", k), clear_index[k*XW +: XW], g[k]);
            pre[k] = m_ram[g[k]];
        end
        overlap = 0;
        for (int k = 0; k < IW; k++)
            for (int p = 0; p < DW; p++)
                if (clear_en[k] && dv[p] && clear_index[k*XW +: XW] == di[p*XW +: XW]) overlap++;
        check("wr_grant_overlap", overlap, 0);
        @(posedge clk);
        if (!stalled) begin
            m_valid = exp_en;
            for (int k = 0; k < g.size(); k++) begin
                m_idx[k] = g[k];
                m_pay[k] = pre[k];
            end
            if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % RS;
        end
        for (int p = 0; p < DW; p++)
            if (dv[p]) m_ram[di[p*XW +: XW]] = dp[p*PW +: PW];
        #1;
        check("iss_valid", iss_valid, m_valid);
        for (int k = 0; k < IW; k++) begin
            if (m_valid[k]) begin
                check($sformatf("iss_index[%0d]", k), iss_index[k*XW +: XW], m_idx[k]);
                check($sformatf("iss_payload[%0d]", k), iss_payload[k*PW +: PW], m_pay[k]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #12;
        check("por_iss_valid", iss_valid, 0);
        check("por_clear_en", clear_en, 0);
        @(negedge clk);
        rst = 1'b1;

        // Dispatch rows 3 and 7, then request both.
        step(2'b11, {4'd7, 4'd3}, {64'hB, 64'hA}, 16'h0000, 1'b1);
        step(2'b00, '0, '0, 16'h0088, 1'b1);
        check("t1_clear_en", last_en, 2'b11);
        check("t1_clear_index", last_ci, {4'd7, 4'd3});
        check("t1_iss_valid", iss_valid, 2'b11);
        check("t1_pay0", iss_payload[63:0], 64'hA);
        check("t1_pay1", iss_payload[127:64], 64'hB);
        step(2'b00, '0, '0, 16'hFFFF, 1'b1);
        check("t1_ptr8", last_ci, {4'd9, 4'd8});

        // Round-robin fairness from ptr 0.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(2'b00, '0, '0, 16'hFFFF, 1'b1);
            check("rr_pair", last_ci, {4'(2*c+1), 4'(2*c)});
        end
        step(2'b00, '0, '0, 16'hFFFF, 1'b1);
        check("rr_wrap", last_ci, {4'd1, 4'd0});

        // Wrap-around: move ptr to 14, then 15 and 0 are granted.
        do_reset();
        step(2'b00, '0, '0, 16'h2000, 1'b1);
        check("wrap_single_en", last_en, 2'b01);
        step(2'b00, '0, '0, 16'h8003, 1'b1);
        check("wrap_ci", last_ci, {4'd0, 4'd15});
        step(2'b00, '0, '0, 16'h0002, 1'b1);
        check("wrap_next", last_ci[3:0], 4'd1);

        // Stall with both slots valid.
        do_reset();
        step(2'b00, '0, '0, 16'h0003, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(2'b00, '0, '0, 16'h00F0, 1'b0);
            check("stall_clear_en", last_en, 2'b00);
            check("stall_iss_index", iss_index, {4'd1, 4'd0});
        end
        step(2'b00, '0, '0, 16'h00F0, 1'b1);
        check("unstall_ci", last_ci, {4'd5, 4'd4});

        // Both dispatch ports hit row 5: port1 wins.
        step(2'b11, {4'd5, 4'd5}, {64'h22, 64'h11}, 16'h0000, 1'b1);
        step(2'b00, '0, '0, 16'h0020, 1'b1);
        check("conf_clear_en", last_en, 2'b01);
        check("conf_iss_valid", iss_valid, 2'b01);
        check("conf_pay", iss_payload[63:0], 64'h22);

        // Async reset asserted mid-stall between edges.
        step(2'b00, '0, '0, 16'h0003, 1'b1);
        iss_ready = 1'b0;
        req_vec   = 16'h00F0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_iss_valid", iss_valid, 0);
        check("arst_clear_en", clear_en, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2'b00, '0, '0, 16'h0004, 1'b1);
        check("arst_grant", last_ci[3:0], 4'd2);
        check("arst_pay", iss_payload[63:0], 64'h0);

        // Random traffic; requests never target a row written in the same cycle.
        for (int c = 0; c < 400; c++) begin
            logic [DW-1:0]    dv;
            logic [DW*XW-1:0] di;
            logic [DW*PW-1:0] dp;
            logic [RS-1:0]    rq;
            logic             rdy;
            dv  = DW'($urandom);
            di  = (DW*XW)'($urandom);
            dp  = {$urandom, $urandom, $urandom, $urandom};
            rq  = RS'($urandom) & RS'($urandom);
            rdy = ($urandom_range(3, 0) != 0);
            for (int p = 0; p < DW; p++) if (dv[p]) rq[di[p*XW +: XW]] = 1'b0;
            step(dv, di, dp, rq, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rr_multi_issue_select.md
Name: rr_multi_issue_select

Overview:
- Parametrised successor to the single-grant select stage.
- Holds the reservation-station payload RAM with DISP_WIDTH write ports.
- Each cycle, picks up to ISSUE_WIDTH ready entries from the wakeup request vector using a rotating (round-robin) priority pointer, so no entry starves.
- Clears the granted RS entries and presents the granted payloads to register read through a registered valid/ready issue stage.

Parameters:
- RS_ENTRIES, 16: reservation-station entries, and the number of payload RAM rows.
- ISSUE_WIDTH, 2: maximum grants (issue slots) per cycle.
- DISP_WIDTH, 2: payload RAM write ports from dispatch.
- PAYLOAD_W, 64: bits per payload entry (packed Disp_uOP).
- IDX_W, $clog2(RS_ENTRIES): entry index width. Derived; do not override.

Ports:
- clk  in  1  clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- disp_valid  in  DISP_WIDTH  per-port payload write enable.
- disp_index  in  DISP_WIDTH*IDX_W  per-port target RAM row.
- disp_payload  in  DISP_WIDTH*PAYLOAD_W  per-port write data.
- req_vec  in  RS_ENTRIES  wakeup request vector; bit i means entry i is ready.
- clear_en  out  ISSUE_WIDTH  per-slot RS clear strobe (combinational, same cycle as grant).
- clear_index  out  ISSUE_WIDTH*IDX_W  per-slot entry to clear.
- iss_valid  out  ISSUE_WIDTH  registered per-slot issue valid.
- iss_index  out  ISSUE_WIDTH*IDX_W  registered granted entry index.
- iss_payload  out  ISSUE_WIDTH*PAYLOAD_W  registered granted payload.
- iss_ready  in  1  register read accepts all slots this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - iss_valid=0, iss_index=0, iss_payload=0.
  - Priority pointer ptr=0; all payload RAM rows = 0.
  - clear_en=0 while rst=0.
- Stall: stall = |iss_valid & !iss_ready.
  - While stalled: no grants, clear_en=0, and all iss_* registers and ptr hold.
- Selection (not stalled, cycle N):
  - Scan req_vec circularly, starting at index ptr, ascending with wrap at RS_ENTRIES-1 -> 0.
  - Slot k is granted the (k+1)-th set bit found.
  - With fewer than ISSUE_WIDTH set bits, the upper slots get clear_en=0, and clear_index is don't-care.
  - Slots fill in order with no gaps: clear_en is always a contiguous low-order mask.
- Clear: clear_en[k]/clear_index[k] are asserted combinationally in cycle N for every granted slot k.
- Issue latency: at the clk edge ending cycle N, each slot k loads:
  - iss_valid[k]=clear_en[k];
  - iss_index[k]=clear_index[k];
  - iss_payload[k]=RAM[clear_index[k]], read combinationally in cycle N (pre-write contents).
  - Result: one cycle from grant to iss_valid.
- Slots with no grant load iss_valid=0 when not stalled. Payload/index for those slots are don't-care; the implementation holds them.
- Pointer update (not stalled, at least one grant): ptr <= (last granted index + 1) mod RS_ENTRIES. With no grant, ptr holds.
- Payload RAM write: at the clk edge, for each p with disp_valid[p], RAM[disp_index[p]] <= disp_payload[p].
  - Writes occur regardless of stall.
  - If two ports target the same index in one cycle, the highest-numbered port wins.
- Same-cycle dispatch write and grant of the same index is illegal. Req_vec must not assert an entry before the cycle after its write.
  - If it happens anyway, the issued payload is the pre-write RAM value; the bench asserts it never occurs.
- req_vec bits for entries already granted are the RS's responsibility to drop. This block does not mask re-requests; a re-request is granted again.
- Reset mid-operation: in-flight issue slots are dropped and iss_valid falls immediately (asynchronous). The first grant after reset release scans from index 0.

Test Plan:
- Reset, then dispatch rows 3 and 7 (port0 -> 3 = 0xA, port1 -> 7 = 0xB), then req_vec=0x0088 one cycle later:
  - clear_en=2'b11, clear_index={7,3};
  - next cycle iss_valid=2'b11, iss_payload slot0=0xA, slot1=0xB;
  - ptr=8.
- Round-robin fairness: hold req_vec=0xFFFF with iss_ready=1 for 8 cycles from ptr=0 -> slot pairs (0,1), (2,3), ... (14,15); ptr wraps to 0.
- Wrap-around: ptr=14, req_vec=0x8003 -> grants slot0=15, slot1=0; ptr becomes 1; entry 1 is granted next cycle if still requested.
- Stall: iss_valid=2'b11, iss_ready=0 for 3 cycles with req_vec=0x00F0 -> clear_en=0, iss_* and ptr frozen. iss_ready=1 -> grants 4,5 that cycle.
- Dispatch port conflict: both ports write row 5 (0x11 on port0, 0x22 on port1), later grant 5 -> iss_payload=0x22. Single request -> clear_en=2'b01, iss_valid=2'b01.
- Async reset asserted mid-stall, between clk edges -> iss_valid=0 immediately. After release, req_vec=0x0004 -> grant 2 from ptr=0, and the issued payload is 0.
